// File: rtl/aes_gf_pkg.sv
// Shared AES GF(2^8) constants, MixColumns coefficient rows, FSM state type
// and byte-index helpers for the column engine.
package aes_gf_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned COL_W  = 32;

  // x^8 + x^4 + x^3 + x + 1
  localparam logic [8:0] AES_POLY = 9'h11B;

  // Coefficient rows, byte 0 in [31:24]; byte i multiplies s_{(r+i) mod 4}
  localparam logic [COL_W-1:0] MIX_FWD = 32'h02030101;
  localparam logic [COL_W-1:0] MIX_INV = 32'h0E0B0D09;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // (r + i) mod 4; the 2-bit add wraps naturally
  function automatic logic [1:0] rot_idx(input logic [1:0] r, input logic [1:0] i);
    return 2'(r + i);
  endfunction

  // Byte i of a column, byte 0 being the most significant (row 0)
  function automatic logic [BYTE_W-1:0] col_byte(input logic [COL_W-1:0] w,
                                                 input logic [1:0] i);
    logic [BYTE_W-1:0] b;
    case (i)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/gf_mul8.sv
// Combinational GF(2^8) multiplier: carry-less 8x8 product reduced modulo
// AES_POLY.
// Ports: a, b - operand bytes; p - reduced product byte.
module gf_mul8 #(
  parameter logic [8:0] AES_POLY = aes_gf_pkg::AES_POLY
) (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  localparam int unsigned PROD_W = 15;

  logic [PROD_W-1:0] prod;

  // Shift-and-xor product, then fold bits 14..8 back with the polynomial
  always_comb begin
    prod = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) prod = prod ^ (PROD_W'(a) << i);
    end
    for (int k = PROD_W - 1; k >= 8; k--) begin
      if (prod[k]) prod = prod ^ (PROD_W'(AES_POLY) << (k - 8));
    end
    p = prod[7:0];
  end

endmodule

// File: rtl/mix_column_unit.sv
// Iterative AES MixColumns / InvMixColumns for one 32-bit column, one output
// byte per clock through four shared GF(2^8) multipliers.
// Ports: clk, rst (async active-high); in_valid/in_ready/in_col/in_inv -
// upstream column handshake; out_valid/out_ready/out_col - result handshake.
module mix_column_unit #(
  parameter logic [8:0] AES_POLY = aes_gf_pkg::AES_POLY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_col,
  input  logic        in_inv,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_col
);

  import aes_gf_pkg::*;

  state_t             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               inv_q, inv_d;
  logic [COL_W-1:0]   res_d;
  logic               valid_d;

  logic [BYTE_W-1:0]  mul_a [4];
  logic [BYTE_W-1:0]  mul_c [4];
  logic [BYTE_W-1:0]  mul_p [4];
  logic [BYTE_W-1:0]  d_byte;
  logic [COL_W-1:0]   coef_row;

  // Gated by rst so upstream never sees ready during reset
  assign in_ready = (state_q == IDLE) && !rst;

  // Operand selection for output byte r = cnt_q
  always_comb begin
    coef_row = inv_q ? MIX_INV : MIX_FWD;
    for (int i = 0; i < 4; i++) begin
      mul_a[i] = col_byte(col_q, rot_idx(cnt_q, 2'(i)));
      mul_c[i] = col_byte(coef_row, 2'(i));
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_mul
    gf_mul8 #(.AES_POLY(AES_POLY)) u_mul (
      .a (mul_a[g]),
      .b (mul_c[g]),
      .p (mul_p[g])
    );
  end

  assign d_byte = mul_p[0] ^ mul_p[1] ^ mul_p[2] ^ mul_p[3];

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    inv_d   = inv_q;
    res_d   = out_col;
    valid_d = out_valid;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          col_d   = in_col;
          inv_d   = in_inv;
          res_d   = '0;
          cnt_d   = 2'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        case (cnt_q)
          2'd0:    res_d[31:24] = d_byte;
          2'd1:    res_d[23:16] = d_byte;
          2'd2:    res_d[15:8]  = d_byte;
          default: res_d[7:0]   = d_byte;
        endcase
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = DONE;
          valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      col_q     <= '0;
      inv_q     <= 1'b0;
      out_col   <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      inv_q     <= inv_d;
      out_col   <= res_d;
      out_valid <= valid_d;
    end
  end

endmodule
